// File: rtl/counter_sequencer.sv
// Start/abort/hold controlled up-counter that runs 0..Limit once or repeatedly,
// pulsing Done per completed period and Err on a rejected (zero-limit) Start.
module counter_sequencer #(
  parameter int WIDTH  = 16,
  parameter int PWIDTH = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Abort,
  input  logic              Hold,
  input  logic              Periodic,
  input  logic [WIDTH-1:0]  Limit,
  output logic [WIDTH-1:0]  Y,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [PWIDTH-1:0] PCount
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [WIDTH-1:0]  Y_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  Y_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PWIDTH-1:0] PC_ZERO = {PWIDTH{1'b0}};
  localparam logic [PWIDTH-1:0] PC_ONE  = {{(PWIDTH-1){1'b0}}, 1'b1};
  localparam logic [PWIDTH-1:0] PC_MAX  = {PWIDTH{1'b1}};

  logic [1:0]        state_r, state_s;
  logic [WIDTH-1:0]  y_r, y_s;
  logic [WIDTH-1:0]  lim_r, lim_s;
  logic              mode_r, mode_s;
  logic [PWIDTH-1:0] pcount_r, pcount_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              term_s;

  assign term_s = (y_r == lim_r);

  // Next-state decode: Abort outranks terminal count, which outranks Hold.
  always_comb begin
    state_s  = state_r;
    y_s      = y_r;
    lim_s    = lim_r;
    mode_s   = mode_r;
    pcount_s = pcount_r;
    done_s   = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (Abort) begin
          state_s = IDLE;
        end else if (Start) begin
          if (Limit == Y_ZERO) begin
            err_s = 1'b1;
          end else begin
            lim_s    = Limit;
            mode_s   = Periodic;
            y_s      = Y_ZERO;
            pcount_s = PC_ZERO;
            state_s  = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (Abort) begin
          state_s = IDLE;
          y_s     = Y_ZERO;
        end else if (term_s) begin
          done_s = 1'b1;
          if (pcount_r != PC_MAX) begin
            pcount_s = pcount_r + PC_ONE;
          end else begin
            pcount_s = pcount_r;
          end
          // One-shot parks Y at the limit; periodic wraps on the Done edge.
          if (mode_r) begin
            y_s = Y_ZERO;
          end else begin
            state_s = IDLE;
          end
        end else if (Hold) begin
          state_s = HOLD;
        end else begin
          y_s = y_r + Y_ONE;
        end
      end
      HOLD: begin
        if (Abort) begin
          state_s = IDLE;
          y_s     = Y_ZERO;
        end else if (Hold) begin
          state_s = HOLD;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        y_s     = Y_ZERO;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r  <= IDLE;
      y_r      <= Y_ZERO;
      lim_r    <= Y_ZERO;
      mode_r   <= 1'b0;
      pcount_r <= PC_ZERO;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      y_r      <= y_s;
      lim_r    <= lim_s;
      mode_r   <= mode_s;
      pcount_r <= pcount_s;
      done_r   <= done_s;
      err_r    <= err_s;
    end
  end

  assign Y      = y_r;
  assign Busy   = (state_r == RUN) || (state_r == HOLD);
  assign Done   = done_r;
  assign Err    = err_r;
  assign PCount = pcount_r;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench: a cycle model pushes expected outputs at each posedge,
// and they are compared against two DUT instances (16/8 and 4/2) at negedge.
module tb_counter_sequencer;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start, Abort, Hold, Periodic;
  logic [15:0] la;
  logic [3:0]  lb;

  logic [15:0] Y0;
  logic        Busy0, Done0, Err0;
  logic [7:0]  PCount0;
  logic [3:0]  Y1;
  logic        Busy1, Done1, Err1;
  logic [1:0]  PCount1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  pc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int m_st[2], m_y[2], m_lim[2], m_mode[2], m_pc[2], m_done[2], m_err[2];

  counter_sequencer #(.WIDTH(16), .PWIDTH(8)) dut0 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .Hold(Hold),
    .Periodic(Periodic), .Limit(la), .Y(Y0), .Busy(Busy0), .Done(Done0),
    .Err(Err0), .PCount(PCount0)
  );

  counter_sequencer #(.WIDTH(4), .PWIDTH(2)) dut1 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort), .Hold(Hold),
    .Periodic(Periodic), .Limit(lb), .Y(Y1), .Busy(Busy1), .Done(Done1),
    .Err(Err1), .PCount(PCount1)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_y[i] = 0; m_lim[i] = 0; m_mode[i] = 0;
      m_pc[i] = 0; m_done[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input int wmask, input int pmax, input int lim_in);
    m_done[i] = 0;
    m_err[i]  = 0;
    if (Rst) begin
      m_st[i] = 0; m_y[i] = 0; m_lim[i] = 0; m_mode[i] = 0; m_pc[i] = 0;
    end else if (m_st[i] == 0) begin
      if (!Abort && Start) begin
        if (lim_in == 0) begin
          m_err[i] = 1;
        end else begin
          m_lim[i] = lim_in; m_mode[i] = int'(Periodic);
          m_y[i] = 0; m_pc[i] = 0; m_st[i] = 1;
        end
      end
    end else if (Abort) begin
      m_st[i] = 0; m_y[i] = 0;
    end else if (m_st[i] == 1) begin
      if (m_y[i] == m_lim[i]) begin
        m_done[i] = 1;
        if (m_pc[i] < pmax) m_pc[i]++;
        if (m_mode[i] != 0) m_y[i] = 0;
        else m_st[i] = 0;
      end else if (Hold) begin
        m_st[i] = 2;
      end else begin
        m_y[i] = (m_y[i] + 1) & wmask;
      end
    end else if (!Hold) begin
      m_st[i] = 1;
    end
  endtask

  function automatic exp_t snap(input int i);
    exp_t e;
    e.y    = 16'(m_y[i]);
    e.busy = (m_st[i] != 0);
    e.done = m_done[i][0];
    e.err  = m_err[i][0];
    e.pc   = 8'(m_pc[i]);
    return e;
  endfunction

  // Model advances on the same edge as the DUTs.
  always @(posedge Clk) begin
    model_step(0, 32'hFFFF, 255, int'(la));
    model_step(1, 32'h000F, 3, int'(lb));
    q0.push_back(snap(0));
    q1.push_back(snap(1));
  end

  // Scoreboard compare, half a cycle after the edge.
  always @(negedge Clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("y0", Y0, e.y);
      check("busy0", Busy0, e.busy);
      check("done0", Done0, e.done);
      check("err0", Err0, e.err);
      check("pcount0", PCount0, e.pc);
      check("done_err_excl0", Done0 & Err0, 0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("y1", Y1, e.y);
      check("busy1", Busy1, e.busy);
      check("done1", Done1, e.done);
      check("err1", Err1, e.err);
      check("pcount1", PCount1, e.pc);
    end
  end

  task automatic cyc(input logic st, input logic ab, input logic ho, input logic pe,
                     input logic [15:0] a, input logic [3:0] b);
    Start = st; Abort = ab; Hold = ho; Periodic = pe; la = a; lb = b;
    @(negedge Clk);
  endtask

  task automatic mid_reset();
    #2 Rst = 1'b1;
    #1;
    check("rst_y0", Y0, 0);
    check("rst_busy0", Busy0, 0);
    check("rst_pcount0", PCount0, 0);
    check("rst_y1", Y1, 0);
    model_clear();
    q0.delete();
    q1.delete();
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Abort = 1'b0; Hold = 1'b0; Periodic = 1'b0;
    la = 16'd0; lb = 4'd0;
    model_clear();
    @(negedge Clk);
    check("reset_y", Y0, 0);
    check("reset_busy", Busy0, 0);
    check("reset_done", Done0, 0);
    check("reset_err", Err0, 0);
    check("reset_pcount", PCount0, 0);

    // One-shot, Start on the first edge after reset release
    Rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 4'd3);
    check("oneshot_first_y", Y0, 0);
    check("oneshot_first_busy", Busy0, 1);
    repeat (9) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'd5, 4'd3);
    check("oneshot_y_parked", Y0, 5);
    check("oneshot_busy", Busy0, 0);
    check("oneshot_pcount", PCount0, 1);
    check("oneshot_y1_parked", Y1, 3);

    // Periodic, 10 cycles of Limit=3
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 4'd3);
    repeat (9) cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 4'd3);
    check("periodic_y", Y0, 1);
    check("periodic_pcount", PCount0, 2);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 4'd3);
    check("abort_y", Y0, 0);
    check("abort_busy", Busy0, 0);
    check("abort_pcount_kept", PCount0, 2);

    // Hold at Y=2 with Limit=4: Done three cycles late
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 4'd4);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 4'd4);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'd4, 4'd4);
    check("hold_y_frozen", Y0, 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 4'd4);
    check("hold_resume_y", Y0, 2);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 4'd4);
    check("hold_y4", Y0, 4);
    check("hold_nodone", Done0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 4'd4);
    check("hold_done", Done0, 1);

    // Abort while holding at Y=7
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'd20, 4'd9);
    repeat (7) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'd20, 4'd9);
    check("pre_abort_y", Y0, 7);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'd20, 4'd9);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 16'd20, 4'd9);
    check("abort_hold_y", Y0, 0);
    check("abort_hold_done", Done0, 0);
    check("abort_hold_busy", Busy0, 0);

    // Zero limit rejected
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    check("zero_err", Err0, 1);
    check("zero_busy", Busy0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    check("zero_err_pulse", Err0, 0);

    // Abort beats Start in IDLE
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'd5, 4'd5);
    check("abort_start_idle", Busy0, 0);

    // Terminal count beats Hold
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 4'd2);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 4'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 4'd2);
    check("term_over_hold_done", Done0, 1);
    check("term_over_hold_busy", Busy0, 0);

    // Abort beats terminal count
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 4'd3);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 4'd3);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 4'd3);
    check("abort_term_done", Done0, 0);
    check("abort_term_y", Y0, 0);

    // Reset between edges at Y=9, then restart
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'd12, 4'd12);
    repeat (9) cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'd12, 4'd12);
    check("pre_rst_y", Y0, 9);
    mid_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 4'd2);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 4'd2);
    check("post_rst_y", Y0, 2);
    check("post_rst_pcount", PCount0, 1);

    // Limit 15 periodic for 5 periods: 4-bit wrap and 2-bit saturation
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'd15, 4'd15);
    repeat (80) cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'd15, 4'd15);
    check("wrap_y1", Y1, 0);
    check("sat_pcount1", PCount1, 3);
    check("nosat_pcount0", PCount0, 5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'd15, 4'd15);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [15:0] r;
      r = 16'($urandom_range(0, 6));
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), r, r[3:0]);
    end
    @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the count/limit width in bits.
REQ-002 SHALL have parameter PWIDTH, default 8, giving the completed-period counter width in bits.
REQ-003 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  begin a count sequence; honoured only in IDLE.
REQ-006 Abort  input  1  terminate the sequence immediately; highest priority after Rst.
REQ-007 Hold  input  1  freeze counting while high in RUN.
REQ-008 Periodic  input  1  mode select, sampled with Start: 1 = auto-restart, 0 = one-shot.
REQ-009 Limit  input  WIDTH  terminal count, sampled with Start.
REQ-010 Y  output  WIDTH  current count value (registered).
REQ-011 Busy  output  1  high in RUN or HOLD.
REQ-012 Done  output  1  one-cycle pulse per completed period.
REQ-013 Err  output  1  one-cycle pulse when Start is rejected.
REQ-014 PCount  output  PWIDTH  completed periods since the last accepted Start, saturating.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and HOLD; Busy SHALL be decoded from the state.
REQ-016 In IDLE with Start=1 and Limit!=0: latch Limit into LimReg and Periodic into ModeReg, set Y<=0 and PCount<=0, go to RUN.
REQ-017 In IDLE with Start=1 and Limit==0: Err<=1 for one cycle; stay in IDLE; leave Y, PCount, LimReg and ModeReg unchanged.
REQ-018 In RUN with Y!=LimReg: Y<=Y+1 each cycle, modulo 2^WIDTH arithmetic, no carry output.
REQ-019 In RUN with Y==LimReg: Done<=1 for one cycle and PCount<=PCount+1, saturating at 2^PWIDTH-1.
REQ-020 Y==LimReg case continued: if ModeReg=1, Y<=0 and stay in RUN; if ModeReg=0, hold Y at LimReg and go to IDLE.
REQ-021 Timing: Start accepted at edge k; Y=n after edge k+n; Done high in the cycle after edge k+LimReg+1.
REQ-022 Timing, periodic mode: Y returns to 0 on the same edge that raises Done; the period is LimReg+1 cycles.
REQ-023 In RUN with Hold=1 (terminal check not taken): go to HOLD; Y and PCount frozen.
REQ-024 In HOLD with Hold=1: stay in HOLD, Y frozen.
REQ-025 In HOLD with Hold=0: return to RUN; counting resumes on the next edge.
REQ-026 Terminal-count detection (Y==LimReg) SHALL take priority over Hold in RUN; Hold SHALL be ignored on that cycle.
REQ-027 Abort=1 in RUN or HOLD: go to IDLE with Y<=0; no Done; PCount retained.
REQ-028 Abort=1 in RUN or HOLD SHALL override a simultaneous terminal count and Hold.
REQ-029 Abort=1 in IDLE: no effect; Abort and Start together in IDLE: Abort wins, Start ignored.
REQ-030 Start while Busy SHALL be ignored (no Err); Limit and Periodic changes while Busy SHALL have no effect.
REQ-031 Done and Err SHALL be registered and SHALL never be high simultaneously.

Reset
REQ-032 Rst=1 SHALL immediately force: state=IDLE, Y=0, PCount=0, Done=0, Err=0, Busy=0, LimReg=0, ModeReg=0.
REQ-033 Rst=1 mid-sequence SHALL abandon the sequence with no Done pulse.
REQ-034 After Rst is released, the first Start SHALL be honoured on the first posedge.

Verification
REQ-035 One-shot: Start, Limit=5, Periodic=0 -> Y steps 0..5; Done pulses once in the cycle after Y=5; Busy drops; Y stays 5; PCount=1.
REQ-036 Periodic: Limit=3, Periodic=1, run 10 cycles -> Y=0,1,2,3,0,1,2,3,0,1; Done pulses every 4 cycles; PCount=2.
REQ-037 Hold at Y=2 for 3 cycles with Limit=4 -> Y stays 2 for those 3 cycles, then 3,4; Done is delayed 3 cycles compared with no Hold.
REQ-038 Abort while Hold=1 at Y=7 -> IDLE, Y=0, no Done. Start with Limit=0 -> single Err pulse, Busy stays 0.
REQ-039 Rst asserted between edges at Y=9 (periodic) -> Y=0, Busy=0 immediately; re-Start with Limit=2 works normally.
REQ-040 WIDTH=4, PWIDTH=2, Limit=15, periodic for 5 periods -> Y wraps cleanly at 15; PCount saturates at 3.
